// File: rtl/sr_ctrl_pkg.sv
// sr_ctrl_pkg -- shared types and constants for the SR command generator.
//   sr_state_e      : one-shot FSM state encoding (IDLE, FIRE, WAIT_REL)
//   DEB_CYCLES_DEF  : default number of stable cycles needed to accept a change
package sr_ctrl_pkg;

    localparam int DEB_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        WAIT_REL = 2'd2
    } sr_state_e;

endpackage

// File: rtl/sr_debounce.sv
// sr_debounce -- 2-flop synchronizer followed by a counting debouncer.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears sync flops, counter, deb)
//   raw  : asynchronous, bouncy input
//   deb  : debounced level; flips after DEB_CYCLES consecutive synchronized
//          cycles that disagree with it
// Parameters: DEB_CYCLES (2..255), CNT_W (must hold DEB_CYCLES)
module sr_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            deb   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                // The increment that would make cnt equal DEB_CYCLES is the
                // accepting edge: flip the level and restart the count.
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen -- turns two bouncy pushbutton-style requests into clean set /
// reset commands for a downstream SR flip-flop. Clear always dominates.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   set_raw  : asynchronous, bouncy set request
//   clr_raw  : asynchronous, bouncy clear request
//   s        : registered set command (never together with r)
//   r        : registered reset command
//   conflict : registered; high only when clear dominance suppressed s
// Build option: define SR_ONESHOT_EN for single-cycle pulse outputs driven by
// an IDLE/FIRE/WAIT_REL FSM; otherwise outputs follow the debounced levels.
module sr_cmd_gen
    import sr_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic set_raw,
    input  logic clr_raw,
    output logic s,
    output logic r,
    output logic conflict
);

    logic set_deb;
    logic clr_deb;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_set (
        .clk (clk),
        .rst (rst),
        .raw (set_raw),
        .deb (set_deb)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_clr (
        .clk (clk),
        .rst (rst),
        .raw (clr_raw),
        .deb (clr_deb)
    );

`ifdef SR_ONESHOT_EN
    sr_state_e state;
    logic      set_deb_d;
    logic      clr_deb_d;
    logic      rise;

    // Rising edge of either debounced request; the delayed copies are cleared
    // by reset so an input held through reset looks like a fresh press.
    assign rise = (set_deb & ~set_deb_d) | (clr_deb & ~clr_deb_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            set_deb_d <= 1'b0;
            clr_deb_d <= 1'b0;
            s         <= 1'b0;
            r         <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            set_deb_d <= set_deb;
            clr_deb_d <= clr_deb;
            s         <= 1'b0;
            r         <= 1'b0;
            conflict  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        // Pulse is registered on entry so it is high for
                        // exactly the FIRE cycle.
                        state    <= FIRE;
                        r        <= clr_deb;
                        s        <= set_deb & ~clr_deb;
                        conflict <= set_deb & clr_deb;
                    end
                end
                FIRE:     state <= WAIT_REL;
                WAIT_REL: if (!set_deb && !clr_deb) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            s        <= set_deb & ~clr_deb;
            r        <= clr_deb;
            conflict <= set_deb & clr_deb;
        end
    end
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen -- self-checking bench for sr_cmd_gen (DEB_CYCLES=4).
// Covers the build selected by SR_ONESHOT_EN: a vector table, hand-timed
// edge sequences, and a long random run against a history-based model.
module tb_sr_cmd_gen;

    localparam int DEB   = 4;
    localparam int H     = DEB + 2;
    localparam int INF   = 1000000;
    localparam int NEVER = 1000000;

    logic clk = 1'b0;
    logic rst;
    logic set_raw;
    logic clr_raw;
    logic s;
    logic r;
    logic conflict;

    sr_cmd_gen #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_raw  (set_raw),
        .clr_raw  (clr_raw),
        .s        (s),
        .r        (r),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // s and r must never be high together, in any mode, at any time.
    always @(negedge clk) begin
        if (rst === 1'b0) check("s_and_r_exclusive", int'(s & r), 0);
    end

    // ---------------- hand sequences: edge-relative intervals ----------------
    int    base;
    int    s_lo, s_hi, r_lo, r_hi, c_lo, c_hi;
    string seq;

    task automatic set_iv(input string nm, input int a, input int b, input int c,
                          input int d, input int e, input int f);
        seq = nm; s_lo = a; s_hi = b; r_lo = c; r_hi = d; c_lo = e; c_hi = f;
    endtask

    function automatic int in_iv(input int v, input int lo, input int hi);
        return (v >= lo && v <= hi) ? 1 : 0;
    endfunction

    task automatic adv(input int k);
        int rel;
        while (edge_n - base < k) begin
            @(negedge clk);
            rel = edge_n - base;
            check({seq, ".s"}, int'(s), in_iv(rel, s_lo, s_hi));
            check({seq, ".r"}, int'(r), in_iv(rel, r_lo, r_hi));
            check({seq, ".conflict"}, int'(conflict), in_iv(rel, c_lo, c_hi));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; set_raw = 1'b0; clr_raw = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset.s", int'(s), 0);
        check("reset.r", int'(r), 0);
        check("reset.conflict", int'(conflict), 0);
        rst  = 1'b0;
        base = edge_n;
    endtask

    // ---------------- reference model ----------------
    // Debounced level flips when the last DEB synchronized samples (raw as
    // sampled two edges earlier) all disagree with it.
    logic [H-1:0] hs, hc;
    logic ds, dc, ps, pc;
    int   phase;  // 0 idle, 1 firing, 2 waiting for release
    logic es, er, ec;

    task automatic model_step(input logic rs, input logic sv, input logic cv);
        logic os, oc, all_s, all_c;
        if (rs) begin
            hs = '0; hc = '0; ds = 0; dc = 0; ps = 0; pc = 0;
            phase = 0; es = 0; er = 0; ec = 0;
            return;
        end
        hs = {hs[H-2:0], sv};
        hc = {hc[H-2:0], cv};
        os = ds; oc = dc;
        all_s = 1'b1; all_c = 1'b1;
        for (int j = 2; j < H; j++) begin
            if (hs[j] == os) all_s = 1'b0;
            if (hc[j] == oc) all_c = 1'b0;
        end
`ifdef SR_ONESHOT_EN
        es = 0; er = 0; ec = 0;
        if (phase == 0) begin
            if ((os && !ps) || (oc && !pc)) begin
                phase = 1;
                er = oc; es = os & ~oc; ec = os & oc;
            end
        end else if (phase == 1) begin
            phase = 2;
        end else if (!os && !oc) begin
            phase = 0;
        end
`else
        es = os & ~oc; er = oc; ec = os & oc;
`endif
        ps = os; pc = oc;
        ds = all_s ? ~os : os;
        dc = all_c ? ~oc : oc;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int set_v; int clr_v; int hold; int es; int er; int ec;
    } vec_t;
    vec_t tbl[12];

    initial begin
        int cs, cr, cc;
        int bouncy;
        rst = 1'b1; set_raw = 1'b0; clr_raw = 1'b0;

        // Level build: expected = final output levels after the hold.
        // One-shot build: expected = number of high cycles during the hold.
`ifdef SR_ONESHOT_EN
        tbl[0]  = '{1, 0, 8, 1, 0, 0};
        tbl[1]  = '{1, 1, 8, 0, 0, 0};
        tbl[2]  = '{0, 1, 8, 0, 0, 0};
        tbl[3]  = '{0, 0, 8, 0, 0, 0};
        tbl[4]  = '{0, 1, 8, 0, 1, 0};
        tbl[5]  = '{1, 1, 8, 0, 0, 0};
        tbl[6]  = '{0, 0, 8, 0, 0, 0};
        tbl[7]  = '{1, 0, 3, 0, 0, 0};
        tbl[8]  = '{0, 0, 8, 0, 0, 0};
        tbl[9]  = '{1, 1, 8, 0, 1, 1};
        tbl[10] = '{1, 0, 8, 0, 0, 0};
        tbl[11] = '{0, 0, 8, 0, 0, 0};
`else
        tbl[0]  = '{1, 0, 8, 1, 0, 0};
        tbl[1]  = '{1, 1, 8, 0, 1, 1};
        tbl[2]  = '{0, 1, 8, 0, 1, 0};
        tbl[3]  = '{0, 0, 8, 0, 0, 0};
        tbl[4]  = '{0, 1, 8, 0, 1, 0};
        tbl[5]  = '{1, 1, 8, 0, 1, 1};
        tbl[6]  = '{0, 0, 8, 0, 0, 0};
        tbl[7]  = '{1, 0, 3, 0, 0, 0};
        tbl[8]  = '{0, 0, 8, 0, 0, 0};
        tbl[9]  = '{1, 1, 8, 0, 1, 1};
        tbl[10] = '{1, 0, 8, 1, 0, 0};
        tbl[11] = '{0, 0, 8, 0, 0, 0};
`endif

        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_raw = 1'(tbl[i].set_v);
            clr_raw = 1'(tbl[i].clr_v);
            cs = 0; cr = 0; cc = 0;
            repeat (tbl[i].hold) begin
                @(negedge clk);
                cs += int'(s); cr += int'(r); cc += int'(conflict);
            end
`ifdef SR_ONESHOT_EN
            check($sformatf("tbl%0d.s_pulses", i), cs, tbl[i].es);
            check($sformatf("tbl%0d.r_pulses", i), cr, tbl[i].er);
            check($sformatf("tbl%0d.conflict_pulses", i), cc, tbl[i].ec);
`else
            check($sformatf("tbl%0d.s", i), int'(s), tbl[i].es);
            check($sformatf("tbl%0d.r", i), int'(r), tbl[i].er);
            check($sformatf("tbl%0d.conflict", i), int'(conflict), tbl[i].ec);
`endif
        end

        // Short glitch: raw high for 3 sampled edges never gets accepted.
        do_reset();
        set_iv("glitch", NEVER, -1, NEVER, -1, NEVER, -1);
        adv(9);  set_raw = 1'b1;
        adv(12); set_raw = 1'b0;
        adv(25);

        // Both requests rise together at edge 20: clear wins.
        do_reset();
`ifdef SR_ONESHOT_EN
        set_iv("both", NEVER, -1, 26, 26, 26, 26);
`else
        set_iv("both", NEVER, -1, 26, INF, 26, INF);
`endif
        adv(19); set_raw = 1'b1; clr_raw = 1'b1;
        adv(30);

        // Reset pulse at edge 13 during a set debounce started at edge 10;
        // set stays held so the request restarts from edge 14.
        do_reset();
`ifdef SR_ONESHOT_EN
        set_iv("rst_mid", 20, 20, NEVER, -1, NEVER, -1);
`else
        set_iv("rst_mid", 20, INF, NEVER, -1, NEVER, -1);
`endif
        adv(9);  set_raw = 1'b1;
        adv(12); rst = 1'b1;
        adv(13); rst = 1'b0;
        adv(25);

`ifdef SR_ONESHOT_EN
        // Single set press: one-cycle pulse after edge 16.
        do_reset();
        set_iv("set_press", 16, 16, NEVER, -1, NEVER, -1);
        adv(9); set_raw = 1'b1;
        adv(22);

        // Clear pressed while set held is ignored until both are released.
        do_reset();
        set_iv("wait_rel", 16, 16, 46, 46, NEVER, -1);
        adv(9);  set_raw = 1'b1;
        adv(19); clr_raw = 1'b1;
        adv(30); set_raw = 1'b0; clr_raw = 1'b0;
        adv(39); clr_raw = 1'b1;
        adv(50);
`else
        // Set then clear: s until clr_deb rises, then r and conflict.
        do_reset();
        set_iv("level_sc", 16, 25, 26, INF, 26, INF);
        adv(9);  set_raw = 1'b1;
        adv(19); clr_raw = 1'b1;
        adv(32);
`endif

        // Random run: alternating stable and bouncy stretches, rare resets.
        @(negedge clk);
        bouncy = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 24 == 0) bouncy = ($urandom_range(0, 2) == 0) ? 1 : 0;
            rst = (i == 0 || $urandom_range(0, 249) == 0) ? 1'b1 : 1'b0;
            if (bouncy != 0) begin
                if ($urandom_range(0, 1) == 0) set_raw = ~set_raw;
                if ($urandom_range(0, 1) == 0) clr_raw = ~clr_raw;
            end else begin
                if ($urandom_range(0, 15) == 0) set_raw = ~set_raw;
                if ($urandom_range(0, 15) == 0) clr_raw = ~clr_raw;
            end
            model_step(rst, set_raw, clr_raw);
            @(negedge clk);
            check("rand.s", int'(s), int'(es));
            check("rand.r", int'(r), int'(er));
            check("rand.conflict", int'(conflict), int'(ec));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
